// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: turns make codes into one-cycle keyCode pulses, stripping E0/F0 prefixes.
// Optional macro PS2_TYPEMATIC_EN: when defined, auto-repeat makes are emitted instead of suppressed.
module ps2_keycode_decoder #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2        // minimum 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] keyCode,
    output logic       keyValid,
    output logic       extended,
    output logic       frameError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TW-1:0]          timeout_q, timeout_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic [7:0]             last_key_q, last_key_d;
    logic [7:0]             key_code_q, key_code_d;
    logic                   key_valid_q, key_valid_d;
    logic                   extended_q, extended_d;
    logic                   frame_err_q, frame_err_d;

    logic ps2_clk_s, ps2_data_s, fall;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        last_key_d  = last_key_q;
        key_code_d  = 8'h00;
        key_valid_d = 1'b0;
        extended_d  = 1'b0;
        frame_err_d = 1'b0;
        timeout_d   = (fall || state_q == ST_IDLE) ? '0 : timeout_q + 1'b1;

        if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!ps2_data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2_data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = ps2_data_s;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // Odd parity over data+parity means the XOR reduction is 1.
                    if (ps2_data_s && ^{shift_q, parity_q}) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else if (brk_q) begin
                            ext_d = 1'b0;
                            brk_d = 1'b0;
                            if (shift_q == last_key_q) last_key_d = 8'h00;
                        end else begin
                            ext_d = 1'b0;
`ifdef PS2_TYPEMATIC_EN
                            key_code_d  = shift_q;
                            key_valid_d = 1'b1;
                            extended_d  = ext_q;
                            last_key_d  = shift_q;
`else
                            if (shift_q != last_key_q) begin
                                key_code_d  = shift_q;
                                key_valid_d = 1'b1;
                                extended_d  = ext_q;
                                last_key_d  = shift_q;
                            end
`endif
                        end
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: synchronizers reset to the idle-high line level so reset never fakes a fall.
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            timeout_q   <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            last_key_q  <= 8'h00;
            key_code_q  <= 8'h00;
            key_valid_q <= 1'b0;
            extended_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2Data};
            clk_prev_q  <= ps2_clk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timeout_q   <= timeout_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            last_key_q  <= last_key_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            extended_q  <= extended_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign keyCode    = key_code_q;
    assign keyValid   = key_valid_q;
    assign extended   = extended_q;
    assign frameError = frame_err_q;

endmodule
